// File: rtl/ctrl_bin_mgr.sv
// rtl/ctrl_bin_mgr.sv - bin-by-bin load / sat-core / backtrack sequencer
// Optional statistics counters are enabled by defining CTRL_BIN_MGR_STAT_EN.
module ctrl_bin_mgr #(
  parameter int WIDTH_BIN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH_BIN-1:0] num_bins_i,
  output logic                 start_load_o,
  output logic [WIDTH_BIN-1:0] load_bin_num_o,
  input  logic                 done_load_i,
  output logic                 core_clr_o,
  output logic                 start_core_o,
  input  logic                 done_core_i,
  input  logic                 sat_i,
  input  logic                 unsat_i,
  input  logic [WIDTH_BIN-1:0] bkt_bin_num_i,
  output logic                 start_bkt_o,
  input  logic                 done_bkt_i,
  output logic [WIDTH_BIN-1:0] bkt_bin_num_o,
  output logic [WIDTH_BIN-1:0] cur_bin_num_o,
  output logic                 done_o,
  output logic                 global_sat_o,
  output logic                 global_unsat_o,
  output logic                 err_o,
  output logic [31:0]          load_cnt_o,
  output logic [31:0]          bkt_cnt_o
);

  typedef enum logic [2:0] {IDLE, LOAD, CORE_CLR, CORE_RUN, BKT, FINISH} state_t;

  state_t               state_q, state_d;
  logic                 first_q, first_d;
  logic [WIDTH_BIN-1:0] num_bins_q, num_bins_d;
  logic [WIDTH_BIN-1:0] cur_bin_q, cur_bin_d;
  logic [WIDTH_BIN-1:0] bkt_q, bkt_d;
  logic                 done_q, done_d;
  logic                 sat_q, sat_d;
  logic                 unsat_q, unsat_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic [WIDTH_BIN-1:0] last_bin;

  assign accept   = (state_q == IDLE) && start_i;
  assign last_bin = num_bins_q - WIDTH_BIN'(1);

  always_comb begin
    state_d    = state_q;
    num_bins_d = num_bins_q;
    cur_bin_d  = cur_bin_q;
    bkt_d      = bkt_q;
    done_d     = done_q;
    sat_d      = sat_q;
    unsat_d    = unsat_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          done_d  = 1'b0;
          unsat_d = 1'b0;
          err_d   = 1'b0;
          if (num_bins_i != '0) begin
            num_bins_d = num_bins_i;
            cur_bin_d  = '0;
            sat_d      = 1'b0;
            state_d    = LOAD;
          end else begin
            sat_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end
      LOAD:     if (done_load_i) state_d = CORE_CLR;
      CORE_CLR: state_d = CORE_RUN;
      CORE_RUN: begin
        if (done_core_i) begin
          if (sat_i && !unsat_i) begin
            if (cur_bin_q == last_bin) begin
              sat_d   = 1'b1;
              state_d = FINISH;
            end else begin
              cur_bin_d = cur_bin_q + WIDTH_BIN'(1);
              state_d   = LOAD;
            end
          end else if (unsat_i && !sat_i) begin
            // all-ones target means the search has backtracked past bin 0
            if (&bkt_bin_num_i) begin
              unsat_d = 1'b1;
              state_d = FINISH;
            end else if (bkt_bin_num_i < cur_bin_q) begin
              bkt_d   = bkt_bin_num_i;
              state_d = BKT;
            end else begin
              err_d   = 1'b1;
              state_d = FINISH;
            end
          end else begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end
      BKT: begin
        if (done_bkt_i) begin
          cur_bin_d = bkt_q;
          state_d   = LOAD;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    first_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      num_bins_q <= '0;
      cur_bin_q  <= '0;
      bkt_q      <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      unsat_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      num_bins_q <= num_bins_d;
      cur_bin_q  <= cur_bin_d;
      bkt_q      <= bkt_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
      unsat_q    <= unsat_d;
      err_q      <= err_d;
    end
  end

  // Pulses fire only on the first cycle spent in their state.
  assign start_load_o   = (state_q == LOAD) && first_q;
  assign start_core_o   = (state_q == CORE_RUN) && first_q;
  assign start_bkt_o    = (state_q == BKT) && first_q;
  assign core_clr_o     = (state_q == CORE_CLR);
  assign load_bin_num_o = cur_bin_q;
  assign cur_bin_num_o  = cur_bin_q;
  assign bkt_bin_num_o  = bkt_q;
  assign done_o         = done_q;
  assign global_sat_o   = sat_q;
  assign global_unsat_o = unsat_q;
  assign err_o          = err_q;

`ifdef CTRL_BIN_MGR_STAT_EN
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] bkt_cnt_q, bkt_cnt_d;

  always_comb begin
    load_cnt_d = load_cnt_q;
    bkt_cnt_d  = bkt_cnt_q;
    if (accept) begin
      load_cnt_d = '0;
      bkt_cnt_d  = '0;
    end else begin
      if (start_load_o && !(&load_cnt_q)) load_cnt_d = load_cnt_q + 32'd1;
      if (start_bkt_o && !(&bkt_cnt_q))   bkt_cnt_d  = bkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt_q <= '0;
      bkt_cnt_q  <= '0;
    end else begin
      load_cnt_q <= load_cnt_d;
      bkt_cnt_q  <= bkt_cnt_d;
    end
  end

  assign load_cnt_o = load_cnt_q;
  assign bkt_cnt_o  = bkt_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign load_cnt_o    = '0;
  assign bkt_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_ctrl_bin_mgr.sv
// tb/tb_ctrl_bin_mgr.sv - table-driven scoreboard bench for ctrl_bin_mgr
module tb_ctrl_bin_mgr;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] num_bins_i;
  logic        start_load_o;
  logic [15:0] load_bin_num_o;
  logic        done_load_i;
  logic        core_clr_o;
  logic        start_core_o;
  logic        done_core_i;
  logic        sat_i;
  logic        unsat_i;
  logic [15:0] bkt_bin_num_i;
  logic        start_bkt_o;
  logic        done_bkt_i;
  logic [15:0] bkt_bin_num_o;
  logic [15:0] cur_bin_num_o;
  logic        done_o;
  logic        global_sat_o;
  logic        global_unsat_o;
  logic        err_o;
  logic [31:0] load_cnt_o;
  logic [31:0] bkt_cnt_o;

  ctrl_bin_mgr #(.WIDTH_BIN(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_bins_i(num_bins_i),
    .start_load_o(start_load_o), .load_bin_num_o(load_bin_num_o),
    .done_load_i(done_load_i), .core_clr_o(core_clr_o),
    .start_core_o(start_core_o), .done_core_i(done_core_i),
    .sat_i(sat_i), .unsat_i(unsat_i), .bkt_bin_num_i(bkt_bin_num_i),
    .start_bkt_o(start_bkt_o), .done_bkt_i(done_bkt_i),
    .bkt_bin_num_o(bkt_bin_num_o), .cur_bin_num_o(cur_bin_num_o),
    .done_o(done_o), .global_sat_o(global_sat_o),
    .global_unsat_o(global_unsat_o), .err_o(err_o),
    .load_cnt_o(load_cnt_o), .bkt_cnt_o(bkt_cnt_o)
  );

  always #5 clk = ~clk;

`ifdef CTRL_BIN_MGR_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  // Per-run nibbles, run 0 in the lowest nibble. resp codes:
  // 0 sat, 1 unsat with target from bkt nibble, 2 sat and unsat, 3 unsat past bin 0.
  typedef struct packed {
    logic [15:0] nb;
    logic [31:0] resp;
    logic [31:0] bkt;
    int          nloads;
    logic [31:0] loads;
    int          nbkt;
    bit          esat;
    bit          eunsat;
    bit          eerr;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          ld_dly = 0;
    int          run = 0;
    int          nbkt_seen = 0;
    bit          core_pend = 0;
    bit          bkt_pend = 0;
    logic [15:0] last_bkt = '0;
    logic [3:0]  code;
    int          cyc;
    exp_q.delete();
    for (int k = 0; k < v.nloads; k++) exp_q.push_back({12'h0, v.loads[4*k +: 4]});
    @(negedge clk);
    num_bins_i = v.nb;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (cyc = 0; cyc < 400 && !done_o; cyc++) begin
      done_load_i = 1'b0;
      done_bkt_i  = 1'b0;
      if (ld_dly != 0) begin
        ld_dly--;
        if (ld_dly == 0) done_load_i = 1'b1;
      end
      if (core_clr_o) begin
        done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0;
      end
      if (core_pend && run < 8) begin
        code        = v.resp[4*run +: 4];
        done_core_i = 1'b1;
        sat_i       = (code == 4'd0) || (code == 4'd2);
        unsat_i     = (code != 4'd0);
        bkt_bin_num_i = (code == 4'd3) ? 16'hFFFF : {12'h0, v.bkt[4*run +: 4]};
        last_bkt    = bkt_bin_num_i;
        run++;
        core_pend = 1'b0;
      end
      if (bkt_pend) begin
        done_bkt_i = 1'b1;
        bkt_pend   = 1'b0;
      end
      if (start_load_o) begin
        if (exp_q.size() == 0) check($sformatf("v%0d unexpected load bin", idx), {48'h0, load_bin_num_o}, 64'hFFFF_FFFF);
        else check($sformatf("v%0d load bin", idx), {48'h0, load_bin_num_o}, {48'h0, exp_q.pop_front()});
        ld_dly = 2;
      end
      if (start_core_o) core_pend = 1'b1;
      if (start_bkt_o) begin
        check($sformatf("v%0d bkt target", idx), {48'h0, bkt_bin_num_o}, {48'h0, last_bkt});
        nbkt_seen++;
        bkt_pend = 1'b1;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d done reached", idx), {63'h0, done_o}, 64'h1);
    check($sformatf("v%0d flags sat/unsat/err", idx), {61'h0, global_sat_o, global_unsat_o, err_o},
          {61'h0, v.esat, v.eunsat, v.eerr});
    check($sformatf("v%0d loads left", idx), exp_q.size(), 64'h0);
    check($sformatf("v%0d bkt pulses", idx), nbkt_seen, v.nbkt);
    check($sformatf("v%0d load_cnt", idx), {32'h0, load_cnt_o}, STAT ? v.nloads : 0);
    check($sformatf("v%0d bkt_cnt", idx), {32'h0, bkt_cnt_o}, STAT ? v.nbkt : 0);
    done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0; done_load_i = 1'b0; done_bkt_i = 1'b0;
    bkt_bin_num_i = '0;
  endtask

  initial begin
    int cyc;
    int loads_seen;
    vecs[0] = '{16'd3, 32'h0,      32'h0,      3, 32'h210,    0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'd4, 32'h100,    32'h100,    6, 32'h321210, 1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'd2, 32'h3,      32'h0,      1, 32'h0,      0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'd3, 32'h10,     32'h10,     2, 32'h10,     0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'd3, 32'h2,      32'h0,      1, 32'h0,      0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'd0, 32'h0,      32'h0,      0, 32'h0,      0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'd1, 32'h0,      32'h0,      1, 32'h0,      0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'd2, 32'h10,     32'h0,      4, 32'h1010,   1, 1'b1, 1'b0, 1'b0};

    rst = 1'b0; start_i = 1'b0; num_bins_i = '0; done_load_i = 1'b0;
    done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0; bkt_bin_num_i = '0; done_bkt_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs",
          {start_load_o, core_clr_o, start_core_o, start_bkt_o, done_o, global_sat_o,
           global_unsat_o, err_o, load_bin_num_o, bkt_bin_num_o, cur_bin_num_o},
          64'h0);
    check("reset counters", {load_cnt_o, bkt_cnt_o}, 64'h0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Zero bins: result within two clocks, never a load.
    @(negedge clk);
    num_bins_i = 16'd0; start_i = 1'b1;
    loads_seen = 0;
    for (cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (start_load_o) loads_seen++;
    end
    check("zero bins done/sat", {62'h0, done_o, global_sat_o}, 64'h3);
    check("zero bins loads", loads_seen, 64'h0);

    // Abort in CORE_RUN; a stray start_i while in LOAD must be ignored.
    @(negedge clk);
    num_bins_i = 16'd3; start_i = 1'b1;
    @(negedge clk);
    num_bins_i = 16'd0;
    @(negedge clk);
    start_i = 1'b0;
    done_load_i = 1'b1;
    @(negedge clk);
    done_load_i = 1'b0;
    for (cyc = 0; cyc < 20 && !start_core_o; cyc++) @(negedge clk);
    check("reached core run", {63'h0, start_core_o}, 64'h1);
    #2 rst = 1'b0;
    #1;
    check("async reset outputs",
          {start_load_o, core_clr_o, start_core_o, start_bkt_o, done_o, global_sat_o,
           global_unsat_o, err_o, load_bin_num_o, bkt_bin_num_o, cur_bin_num_o},
          64'h0);
    check("async reset counters", {load_cnt_o, bkt_cnt_o}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("held reset pulses", {60'h0, start_load_o, core_clr_o, start_core_o, start_bkt_o}, 64'h0);
    rst = 1'b1;
    run_vec(vecs[0], 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
